// File: rtl/alu_issue.sv
// Decode/issue stage for the RV32I integer ALU: turns OP/OP-IMM into an ALU operand bundle held in one valid/ready slot.
// Optional macro ALU_ISSUE_UTYPE_EN adds LUI/AUIPC decode; without it those opcodes are treated as illegal.
module alu_issue #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [31:0]        in_pc,
   output logic [4:0]         rs1_addr,
   output logic [4:0]         rs2_addr,
   input  logic [31:0]        rs1_data,
   input  logic [31:0]        rs2_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_a,
   output logic [31:0]        out_b,
   output logic [2:0]         out_op,
   output logic               out_mod,
   output logic [4:0]         out_rd,
   output logic               out_we,
   output logic [31:0]        out_pc,
   output logic               out_illegal,
   output logic [COUNT_W-1:0] illegal_count
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SLL = 3'd1;
   localparam logic [2:0] OP_SR  = 3'd5;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] imm_i;
   logic [31:0] shamt_reg;
   logic [31:0] shamt_imm;

   logic [31:0] dec_a;
   logic [31:0] dec_b;
   logic [2:0]  dec_op;
   logic        dec_mod;
   logic        dec_illegal;
   logic        dec_we;
   logic        accept;

   assign opcode    = in_instr[6:0];
   assign rd        = in_instr[11:7];
   assign funct3    = in_instr[14:12];
   assign funct7    = in_instr[31:25];
   assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
   assign shamt_reg = {27'b0, rs2_data[4:0]};
   assign shamt_imm = {27'b0, in_instr[24:20]};

   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];

   assign in_ready = !rst && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Decode into the operand bundle; anything not explicitly recognised stays illegal with zeroed operands.
   always_comb begin
      dec_a       = '0;
      dec_b       = '0;
      dec_op      = OP_ADD;
      dec_mod     = 1'b0;
      dec_illegal = 1'b1;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE) begin
               dec_illegal = 1'b0;
               dec_a       = rs1_data;
               dec_op      = funct3;
               dec_b       = (funct3 == OP_SLL || funct3 == OP_SR) ? shamt_reg : rs2_data;
            end else if (funct7 == F7_ALT && funct3 == OP_ADD) begin
               dec_illegal = 1'b0;
               dec_a       = rs1_data;
               dec_op      = OP_ADD;
               dec_b       = 32'd0 - rs2_data;
            end else if (funct7 == F7_ALT && funct3 == OP_SR) begin
               dec_illegal = 1'b0;
               dec_a       = rs1_data;
               dec_op      = OP_SR;
               dec_mod     = 1'b1;
               dec_b       = shamt_reg;
            end
         end
         OPC_OPIMM: begin
            case (funct3)
               OP_SLL: begin
                  if (funct7 == F7_BASE) begin
                     dec_illegal = 1'b0;
                     dec_b       = shamt_imm;
                  end
               end
               OP_SR: begin
                  if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                     dec_illegal = 1'b0;
                     dec_mod     = (funct7 == F7_ALT);
                     dec_b       = shamt_imm;
                  end
               end
               default: begin
                  dec_illegal = 1'b0;
                  dec_b       = imm_i;
               end
            endcase
            if (!dec_illegal) begin
               dec_a  = rs1_data;
               dec_op = funct3;
            end
         end
`ifdef ALU_ISSUE_UTYPE_EN
         OPC_LUI: begin
            dec_illegal = 1'b0;
            dec_b       = {in_instr[31:12], 12'b0};
         end
         OPC_AUIPC: begin
            dec_illegal = 1'b0;
            dec_a       = in_pc;
            dec_b       = {in_instr[31:12], 12'b0};
         end
`endif
         default: ;
      endcase
   end

   assign dec_we = !dec_illegal && (rd != 5'd0);

   // Single output slot: reload on accept (covers consume+accept in the same cycle), otherwise empty on consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_a         <= '0;
         out_b         <= '0;
         out_op        <= OP_ADD;
         out_mod       <= 1'b0;
         out_rd        <= '0;
         out_we        <= 1'b0;
         out_pc        <= '0;
         out_illegal   <= 1'b0;
         illegal_count <= '0;
      end else begin
         if (accept) begin
            out_valid   <= 1'b1;
            out_a       <= dec_a;
            out_b       <= dec_b;
            out_op      <= dec_op;
            out_mod     <= dec_mod;
            out_rd      <= rd;
            out_we      <= dec_we;
            out_pc      <= in_pc;
            out_illegal <= dec_illegal;
            if (dec_illegal && illegal_count != COUNT_MAX) begin
               illegal_count <= illegal_count + COUNT_W'(1);
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode/issue stage driving the RV32I integer ALU. Accepts one 32-bit instruction per handshake, decodes OP, OP-IMM and (optionally) LUI/AUIPC into the ALU's `a`/`b`/`op`/`mod` operand bundle, and holds the result in a single registered output slot with valid/ready flow control. It sits between fetch and execute; the register file is read combinationally through the `rs1_addr`/`rs2_addr` ports.

## Interface
- `COUNT_W`, default 16: width of the saturating illegal-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  slot can accept; `!rst && (!out_valid || out_ready)`.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of `in_instr`.
- `rs1_addr`, `rs2_addr`  out  5 each  combinational `in_instr[19:15]`, `in_instr[24:20]`.
- `rs1_data`, `rs2_data`  in  32 each  regfile read data, same cycle.
- `out_valid`  out  1  bundle valid.
- `out_ready`  in  1  execute consumes bundle.
- `out_a`, `out_b`  out  32 each  ALU operands.
- `out_op`  out  3  ALU op: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SR=5, OR=6, AND=7.
- `out_mod`  out  1  1 = arithmetic right shift.
- `out_rd`  out  5  destination register.
- `out_we`  out  1  writeback enable.
- `out_pc`  out  32  PC of the bundle.
- `out_illegal`  out  1  bundle came from an undecodable instruction.
- `illegal_count`  out  `COUNT_W`  saturating count of illegal instructions accepted.

## Operation
- Accept on `in_valid && in_ready`; decoded bundle registered on that edge.
- OP (0110011): `a=rs1_data`. funct7=0000000: funct3 maps directly to `op`, `b=rs2_data`; exceptions: SLL/SR use `b={27'b0,rs2_data[4:0]}`. funct7=0100000 with funct3=000 (SUB): `op=ADD`, `b=-rs2_data` (two's complement, mod 2^32). funct7=0100000 with funct3=101 (SRA): `op=SR`, `mod=1`, `b={27'b0,rs2_data[4:0]}`. Any other funct7 is illegal.
- OP-IMM (0010011): `a=rs1_data`, `b=sign-extended imm[11:0]`, `op=funct3`. SLLI/SRLI/SRAI: `b={27'b0,instr[24:20]}`. funct7 must be 0000000, or 0100000 for SRAI only (`mod=1`); otherwise illegal.
- `out_mod=0` for all non-SRA/SRAI bundles.
- `out_rd=instr[11:7]`; `out_we=1` unless rd=0 or the bundle is illegal.
- Illegal (any other opcode or bad funct7): `out_illegal=1`, `a=b=0`, `op=ADD`, `mod=0`, `we=0`. `illegal_count` increments on acceptance and saturates at 2^COUNT_W-1.
- The bundle is passed downstream; no trap is raised here.

## Timing
- Latency: 1 cycle, from the accept edge to `out_valid=1`.
- Throughput: 1 instruction per cycle when `out_ready=1`; simultaneous consume and accept replaces the slot with no bubble.
- While `out_valid && !out_ready`, all `out_*` hold stable and `in_ready=0`.
- Consume without a new accept: `out_valid` falls the next cycle.
- Reset values: `out_valid=0`, `out_illegal=0`, `out_we=0`, `out_mod=0`, `out_op=0`, `illegal_count=0`, and all data outputs 0. `in_ready=0` while `rst=1`.
- Reset mid-stall drops the held bundle; no partial state survives.
- `rs1_addr`/`rs2_addr` are purely combinational from `in_instr`, independent of handshake state.

## Configuration
- `ALU_ISSUE_UTYPE_EN` defined: LUI (0110111) decodes to `a=0`, `b={instr[31:12],12'b0}`, `op=ADD`. AUIPC (0010111) decodes to `a=in_pc` and the same `b`. Both use the normal rd/we rules.
- Not defined: LUI and AUIPC are illegal, and `illegal_count` increments.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), `rs1_data=0`, `out_ready=1` -> next cycle `a=0`, `b=0xFFFFFFFF`, `op=0`, `rd=1`, `we=1`.
- SUB x3,x1,x2 (0x402081B3), `rs1_data=10`, `rs2_data=3` -> `a=10`, `b=0xFFFFFFFD`, `op=0`, `mod=0`, `rd=3`.
- SRAI x5,x6,4 (0x40435293), `rs1_data=0x80000000` -> `op=5`, `mod=1`, `b=4`, `rd=5`. SRL with `rs2_data=0x25` -> `b=5`.
- Backpressure: bundle valid, `out_ready=0` for 3 cycles -> `in_ready=0` and outputs unchanged. Raise `out_ready` together with `in_valid` -> new bundle appears the next cycle, no bubble.
- 0x00000000 ×5 with `COUNT_W=2` -> each bundle has `out_illegal=1`, `we=0`; `illegal_count` ends at 3. Assert `rst` mid-stall -> `out_valid=0` and count 0 the next cycle.
- LUI x1,0x12345 (0x123450B7): macro on -> `a=0`, `b=0x12345000`, `op=0`, `we=1`. Macro off -> `out_illegal=1`.
